// File: rtl/adc16dv160_output_common.sv
// Shared definitions for the ADC16DV160 output emulator: modes, FSM states,
// LFSR constants and the DDR even/odd bit-split helper.
package adc16dv160_output_common;

  localparam logic [1:0] MODE_RAMP  = 2'd0;
  localparam logic [1:0] MODE_PULSE = 2'd1;
  localparam logic [1:0] MODE_CONST = 2'd2;

  typedef enum logic [2:0] {IDLE, PRE, PULSE, POST, DONE} state_t;

  localparam int unsigned       LFSR_W    = 16;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  localparam int unsigned SPLIT_MAX_W = 64;

  typedef struct packed {
    logic [SPLIT_MAX_W/2-1:0] odd;
    logic [SPLIT_MAX_W/2-1:0] even;
  } ddr_split_t;

  // Even sample bits go to the rising-edge half, odd bits to the falling-edge half
  function automatic ddr_split_t ddr_split(input logic [SPLIT_MAX_W-1:0] s);
    ddr_split_t r;
    for (int i = 0; i < int'(SPLIT_MAX_W / 2); i++) begin
      r.even[i] = s[2*i];
      r.odd[i]  = s[2*i+1];
    end
    return r;
  endfunction

endpackage

// File: rtl/adc16dv160_output_lfsr.sv
// 16-bit Galois LFSR noise source with advance enable and synchronous reseed.
module adc16dv160_output_lfsr
  import adc16dv160_output_common::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              reseed,
  output logic [LFSR_W-1:0] value
);

  always_ff @(posedge clk) begin
    if (reset || reseed) begin
      value <= LFSR_SEED;
    end else if (en) begin
      value <= (value >> 1) ^ (value[0] ? LFSR_TAPS : '0);
    end
  end

endmodule

// File: rtl/adc16dv160_output_emu.sv
// ADC16DV160 data-source emulator: ramp / pulse / constant frames on a DDR-split bus.
// Optional sample noise is enabled by defining ADC16DV160_OUTPUT_NOISE_EN.
module adc16dv160_output_emu
  import adc16dv160_output_common::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned FRAMES_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic [1:0]          mode,
  input  logic [DATA_W-1:0]   base_level,
  input  logic [DATA_W-1:0]   pulse_level,
  input  logic [CNT_W-1:0]    n_pre,
  input  logic [CNT_W-1:0]    n_pulse,
  input  logic [CNT_W-1:0]    n_post,
  input  logic [FRAMES_W-1:0] n_frames,
  output logic [DATA_W/2-1:0] d_rise,
  output logic [DATA_W/2-1:0] d_fall,
  output logic                d_valid,
  output logic                busy,
  output logic                done,
  output logic [FRAMES_W-1:0] frame_cnt
);

  localparam int unsigned HALF_W = DATA_W / 2;

  state_t              state, state_n, first_state_c;
  logic [CNT_W-1:0]    cnt, cnt_n, first_cnt_c;
  logic [CNT_W-1:0]    pre_sel_c, pulse_sel_c, post_sel_c;
  logic [FRAMES_W-1:0] frame_cnt_n;
  logic [DATA_W-1:0]   ramp, ramp_n;
  logic                start_ok_c, run_c, frame_end_c;

  logic [1:0]          cfg_mode;
  logic [DATA_W-1:0]   cfg_base, cfg_pulse;
  logic [CNT_W-1:0]    cfg_pre, cfg_npulse, cfg_post;
  logic [FRAMES_W-1:0] cfg_frames;

  logic [DATA_W-1:0]   level_c, noisy_c, sample_c;
  ddr_split_t          split_c;
  logic                unused_split;

  assign start_ok_c = (state == IDLE) && start;
  assign run_c      = (state == PRE) || (state == PULSE) || (state == POST);

  // Segment lengths come straight from the ports on the accepted start
  assign pre_sel_c   = (state == IDLE) ? n_pre   : cfg_pre;
  assign pulse_sel_c = (state == IDLE) ? n_pulse : cfg_npulse;
  assign post_sel_c  = (state == IDLE) ? n_post  : cfg_post;

  // First non-empty segment of a frame; an all-zero frame emits one POST sample
  always_comb begin : first_seg
    first_state_c = POST;
    first_cnt_c   = CNT_W'(1);
    if (pre_sel_c != '0) begin
      first_state_c = PRE;
      first_cnt_c   = pre_sel_c;
    end else if (pulse_sel_c != '0) begin
      first_state_c = PULSE;
      first_cnt_c   = pulse_sel_c;
    end else if (post_sel_c != '0) begin
      first_state_c = POST;
      first_cnt_c   = post_sel_c;
    end
  end

  always_comb begin : next_state
    state_n     = state;
    cnt_n       = cnt;
    frame_cnt_n = frame_cnt;
    ramp_n      = ramp;
    frame_end_c = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n     = first_state_c;
          cnt_n       = first_cnt_c;
          frame_cnt_n = '0;
          ramp_n      = '0;
        end
      end
      PRE, PULSE, POST: begin
        if (stop) begin
          state_n = DONE;
        end else begin
          if (cfg_mode == MODE_RAMP) begin
            ramp_n      = ramp + DATA_W'(1);
            frame_end_c = (ramp == '1);
          end else begin
            cnt_n = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              if (state == PRE && cfg_npulse != '0) begin
                state_n = PULSE;
                cnt_n   = cfg_npulse;
              end else if (state != POST && cfg_post != '0) begin
                state_n = POST;
                cnt_n   = cfg_post;
              end else begin
                frame_end_c = 1'b1;
              end
            end
          end
          if (frame_end_c) begin
            if (frame_cnt != '1) frame_cnt_n = frame_cnt + FRAMES_W'(1);
            if (cfg_frames != '0 && (frame_cnt + FRAMES_W'(1)) == cfg_frames) begin
              state_n = DONE;
            end else begin
              state_n = first_state_c;
              cnt_n   = first_cnt_c;
            end
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin : state_reg
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      frame_cnt <= '0;
      ramp      <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      frame_cnt <= frame_cnt_n;
      ramp      <= ramp_n;
    end
  end

  assign level_c = (state == PULSE && cfg_mode == MODE_PULSE) ? cfg_pulse : cfg_base;

`ifdef ADC16DV160_OUTPUT_NOISE_EN
  localparam int unsigned SUM_W = DATA_W + 2;

  logic [LFSR_W-1:0]       lfsr;
  logic signed [SUM_W-1:0] sum_c;
  logic                    unused_lfsr;

  adc16dv160_output_lfsr u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .en     (run_c),
    .reseed (start_ok_c),
    .value  (lfsr)
  );

  assign unused_lfsr = ^lfsr[LFSR_W-1:4];
  assign sum_c       = $signed({2'b00, level_c}) + SUM_W'($signed(lfsr[3:0]));

  // Signed nibble offset, clamped to the unsigned sample range
  always_comb begin : noise_sat
    noisy_c = sum_c[DATA_W-1:0];
    if (sum_c[SUM_W-1])     noisy_c = '0;
    else if (sum_c[DATA_W]) noisy_c = '1;
  end
`else
  assign noisy_c = level_c;
`endif

  always_comb begin : sample_sel
    sample_c = cfg_base;
    case (cfg_mode)
      MODE_RAMP:              sample_c = run_c ? ramp : '0;
      MODE_PULSE, MODE_CONST: sample_c = run_c ? noisy_c : cfg_base;
      default:                sample_c = run_c ? noisy_c : cfg_base;
    endcase
  end

  assign split_c      = ddr_split(SPLIT_MAX_W'(sample_c));
  assign unused_split = ^split_c;

  always_ff @(posedge clk) begin : out_reg
    if (reset) begin
      cfg_mode   <= MODE_RAMP;
      cfg_base   <= '0;
      cfg_pulse  <= '0;
      cfg_pre    <= '0;
      cfg_npulse <= '0;
      cfg_post   <= '0;
      cfg_frames <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      d_valid    <= 1'b0;
      d_rise     <= '0;
      d_fall     <= '0;
    end else begin
      if (start_ok_c) begin
        cfg_mode   <= mode;
        cfg_base   <= base_level;
        cfg_pulse  <= pulse_level;
        cfg_pre    <= n_pre;
        cfg_npulse <= n_pulse;
        cfg_post   <= n_post;
        cfg_frames <= n_frames;
      end
      busy    <= (state_n == PRE) || (state_n == PULSE) || (state_n == POST);
      done    <= (state_n == DONE);
      d_valid <= run_c;
      d_rise  <= split_c.even[HALF_W-1:0];
      d_fall  <= split_c.odd[HALF_W-1:0];
    end
  end

endmodule

// File: tb/tb_adc16dv160_output_emu.sv
// Self-checking bench for adc16dv160_output_emu: directed cases plus random PULSE/CONST jobs
// compared against a sample-sequence model built from the frame rules.
module tb_adc16dv160_output_emu;

  localparam int unsigned DW = 16;
  localparam int unsigned HW = DW / 2;
  localparam int unsigned CW = 32;
  localparam int unsigned FW = 16;

  logic          clk = 1'b0;
  logic          reset, start, stop;
  logic [1:0]    mode;
  logic [DW-1:0] base_level, pulse_level;
  logic [CW-1:0] n_pre, n_pulse, n_post;
  logic [FW-1:0] n_frames;
  logic [HW-1:0] d_rise, d_fall;
  logic          d_valid, busy, done;
  logic [FW-1:0] frame_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  adc16dv160_output_emu dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .mode        (mode),
    .base_level  (base_level),
    .pulse_level (pulse_level),
    .n_pre       (n_pre),
    .n_pulse     (n_pulse),
    .n_post      (n_post),
    .n_frames    (n_frames),
    .d_rise      (d_rise),
    .d_fall      (d_fall),
    .d_valid     (d_valid),
    .busy        (busy),
    .done        (done),
    .frame_cnt   (frame_cnt)
  );

  // Rebuild the sample from the DDR halves: d_rise holds even bits, d_fall odd bits
  function automatic logic [DW-1:0] join_bus(input logic [HW-1:0] r, input logic [HW-1:0] f);
    logic [DW-1:0] s;
    for (int i = 0; i < int'(HW); i++) begin
      s[2*i]   = r[i];
      s[2*i+1] = f[i];
    end
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input string tag, input logic [1:0] m, input logic [DW-1:0] b,
                         input logic [DW-1:0] p, input int unsigned npre, input int unsigned npul,
                         input int unsigned npost, input int unsigned nf, input logic with_stop);
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_s;
    int unsigned   seg;
    int            k, first, got, total, budget;
    logic          seen_done;
    for (int f = 0; f < int'(nf); f++) begin
      if (m == 2'd0) begin
        for (int i = 0; i < (1 << DW); i++) exp_q.push_back(DW'(i));
      end else if (m == 2'd1) begin
        repeat (npre)  exp_q.push_back(b);
        repeat (npul)  exp_q.push_back(p);
        repeat (npost) exp_q.push_back(b);
        if (npre + npul + npost == 0) exp_q.push_back(b);
      end else begin
        seg = npre + npul + npost;
        if (seg == 0) seg = 1;
        repeat (seg) exp_q.push_back(b);
      end
    end
    total  = exp_q.size();
    budget = total + 10;

    mode = m; base_level = b; pulse_level = p;
    n_pre = CW'(npre); n_pulse = CW'(npul); n_post = CW'(npost); n_frames = FW'(nf);
    start = 1'b1; stop = with_stop;
    tick;
    start = 1'b0; stop = 1'b0;
    // Disturb the configuration ports; the running job must not see this
    mode = m ^ 2'd1; base_level = ~b; pulse_level = ~p;
    n_pre = CW'(npre + 1); n_pulse = CW'(npul + 2); n_post = CW'(npost + 1); n_frames = FW'(nf + 2);
    chk({tag, "_busy_after_start"}, 32'(busy), 32'd1);

    k = 1; first = 0; got = 0; seen_done = 1'b0;
    while (!seen_done && k < budget) begin
      tick;
      k++;
      if (d_valid) begin
        if (first == 0) first = k;
        got++;
        if (exp_q.size() > 0) begin
          exp_s = exp_q.pop_front();
          chk({tag, "_sample"}, 32'(join_bus(d_rise, d_fall)), 32'(exp_s));
        end
      end
      if (done) seen_done = 1'b1;
    end
    chk({tag, "_done_seen"}, 32'(seen_done), 32'd1);
    chk({tag, "_sample_count"}, 32'(got), 32'(total));
    chk({tag, "_first_valid_cycle"}, 32'(first), 32'd2);
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(nf));
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    tick;
    chk({tag, "_done_single"}, 32'(done), 32'd0);
    chk({tag, "_valid_after"}, 32'(d_valid), 32'd0);
    chk({tag, "_hold_after"}, 32'(join_bus(d_rise, d_fall)), (m == 2'd0) ? 32'd0 : 32'(b));
  endtask

  initial begin
    logic [DW-1:0] w;
    logic [HW-1:0] ev, od;

    reset = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'd0;
    base_level = '0; pulse_level = '0; n_pre = '0; n_pulse = '0; n_post = '0; n_frames = '0;
    tick; tick;
    reset = 1'b0;
    chk("rst_d_rise", 32'(d_rise), 32'd0);
    chk("rst_d_fall", 32'(d_fall), 32'd0);
    chk("rst_d_valid", 32'(d_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);

    // Stop while idle does nothing
    stop = 1'b1; tick; stop = 1'b0; tick;
    chk("idle_stop_busy", 32'(busy), 32'd0);
    chk("idle_stop_done", 32'(done), 32'd0);

    run_job("pulse", 2'd1, 16'h0100, 16'h8000, 3, 2, 4, 2, 1'b0);
    run_job("zero_len", 2'd1, 16'h0BAD, 16'h7777, 0, 0, 0, 3, 1'b0);
    run_job("const_split", 2'd2, 16'hA5C3, 16'h0000, 1, 1, 1, 1, 1'b0);

    // Bit-split check of a steady CONST sample against per-bit extraction
    w = 16'hA5C3;
    for (int i = 0; i < int'(HW); i++) begin
      ev[i] = w[2*i];
      od[i] = w[2*i+1];
    end
    mode = 2'd3; base_level = w; n_pre = 32'd4; n_pulse = '0; n_post = '0; n_frames = 16'd1;
    start = 1'b1; tick; start = 1'b0; tick; tick;
    chk("split_valid", 32'(d_valid), 32'd1);
    chk("split_rise", 32'(d_rise), 32'(ev));
    chk("split_fall", 32'(d_fall), 32'(od));
    tick; tick; tick; tick;

    run_job("ramp", 2'd0, 16'h1111, 16'h2222, 1, 1, 1, 1, 1'b0);

    // Stop (together with an ignored start) during PULSE on an endless run
    mode = 2'd1; base_level = 16'h1234; pulse_level = 16'h4321;
    n_pre = 32'd2; n_pulse = 32'd5; n_post = 32'd3; n_frames = '0;
    start = 1'b1; tick; start = 1'b0;
    tick; tick; tick;
    chk("stop_pre_valid", 32'(d_valid), 32'd1);
    chk("stop_pre_data", 32'(join_bus(d_rise, d_fall)), 32'h4321);
    start = 1'b1; stop = 1'b1; tick; start = 1'b0; stop = 1'b0;
    chk("stop_done", 32'(done), 32'd1);
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_frame_cnt", 32'(frame_cnt), 32'd0);
    tick;
    chk("stop_valid_after", 32'(d_valid), 32'd0);
    chk("stop_done_single", 32'(done), 32'd0);
    chk("stop_hold", 32'(join_bus(d_rise, d_fall)), 32'h1234);

    // Reset during POST of the second frame
    mode = 2'd1; base_level = 16'h00F0; pulse_level = 16'h0F00;
    n_pre = 32'd1; n_pulse = 32'd1; n_post = 32'd1; n_frames = '0;
    start = 1'b1; tick; start = 1'b0;
    tick; tick; tick; tick; tick;
    chk("mid_frame_cnt", 32'(frame_cnt), 32'd1);
    reset = 1'b1; tick;
    chk("mid_rst_valid", 32'(d_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("mid_rst_data", 32'(join_bus(d_rise, d_fall)), 32'd0);
    tick;
    chk("mid_rst_done_held", 32'(done), 32'd0);
    reset = 1'b0;

    run_job("start_stop_idle", 2'd1, 16'h5A5A, 16'hC3C3, 2, 3, 1, 2, 1'b1);

    for (int j = 0; j < 8; j++) begin
      run_job("rnd", 2'($urandom_range(1, 3)), 16'($urandom), 16'($urandom),
              $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
              $urandom_range(1, 3), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
